sine_duty_gen: RTL and testbench



---
 rtl/sine_pwm_pkg.sv | 16 +
 rtl/sine_quarter_rom.sv | 44 ++++
 rtl/sine_duty_gen.sv | 86 ++++++++
 tb/tb_sine_duty_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sine_pwm_pkg.sv
// Shared constants for the sine PWM chain: default geometry, quadrant codes and
// the quarter-wave ROM image name used by the generator, tick counter and comparator.
package sine_pwm_pkg;
    localparam int PERIOD_DEF  = 1000;
    localparam int PHASE_W_DEF = 32;
    localparam int LUT_AW_DEF  = 8;
    localparam int AMP_W_DEF   = 16;
    localparam int WIDTH_W_DEF = 32;

    localparam logic [1:0] QUAD_0 = 2'd0;
    localparam logic [1:0] QUAD_1 = 2'd1;
    localparam logic [1:0] QUAD_2 = 2'd2;
    localparam logic [1:0] QUAD_3 = 2'd3;

    localparam string ROM_FILE = "sine_quarter.mem";
endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine ROM, one-cycle registered read. Entry k holds
// round((2^DW-1)*sin(pi/2*k/(2^AW-1))), built at elaboration so no image file is needed.
module sine_quarter_rom #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);
    localparam int  DEPTH   = 2 ** AW;
    localparam int  MAXV    = (1 << DW) - 1;
    localparam real HALF_PI = 1.57079632679489661923;

    typedef logic [DEPTH-1:0][DW-1:0] rom_t;

    // Taylor series to x^23 is exact to well below one LSB over [0, pi/2]
    function automatic rom_t build_rom();
        rom_t r;
        real  x, term, s;
        int   v;
        r = '0;
        for (int k = 0; k < DEPTH; k++) begin
            x    = HALF_PI * real'(k) / real'(DEPTH - 1);
            term = x;
            s    = 0.0;
            for (int n = 0; n < 12; n++) begin
                s    = s + term;
                term = -term * x * x / real'((2 * n + 2) * (2 * n + 3));
            end
            v = $rtoi(s * real'(MAXV) + 0.5);
            if (v > MAXV) v = MAXV;
            if (v < 0) v = 0;
            r[k] = DW'(v);
        end
        return r;
    endfunction

    localparam rom_t ROM = build_rom();

    always_ff @(posedge clk) begin
        data <= ROM[addr];
    end
endmodule

// File: rtl/sine_duty_gen.sv
// Phase-accumulator sine duty generator: one sample per tick, producing a PWM
// compare threshold centred on PERIOD/2, four edges after the tick.
module sine_duty_gen
    import sine_pwm_pkg::*;
#(
    parameter int PERIOD  = PERIOD_DEF,
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int LUT_AW  = LUT_AW_DEF,
    parameter int AMP_W   = AMP_W_DEF,
    parameter int WIDTH_W = WIDTH_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               tick,
    input  logic [PHASE_W-1:0] ftw,
    output logic [WIDTH_W-1:0] width,
    output logic               width_valid,
    output logic               sync
);
    localparam int PROD_W = AMP_W + WIDTH_W;
    localparam int STAGES = 3;
    localparam logic [WIDTH_W-1:0] HALF = WIDTH_W'(PERIOD / 2);

    logic [PHASE_W-1:0]  phase;
    logic [PHASE_W:0]    sum;
    logic                carry;
    logic [STAGES:0]     vld_pipe;
    logic [STAGES:0]     sync_pipe;
    logic [LUT_AW+1:0]   top_s0;
    logic [1:0]          quad;
    logic [LUT_AW-1:0]   idx;
    logic [LUT_AW-1:0]   addr_s1;
    logic                sign_s1, sign_s2, sign_s3;
    logic [AMP_W-1:0]    sample_s2;
    logic [PROD_W-1:0]   prod;
    logic [WIDTH_W-1:0]  mag_s3;

    assign sum  = {1'b0, phase} + {1'b0, ftw};
    assign quad = top_s0[LUT_AW+1 -: 2];
    assign idx  = top_s0[LUT_AW-1:0];
    assign prod = PROD_W'(sample_s2) * PROD_W'(PERIOD / 2);

    // Control: reset and en-low both flush the pipe and park width at mid-scale
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            phase       <= '0;
            carry       <= 1'b0;
            vld_pipe    <= '0;
            sync_pipe   <= '0;
            width       <= HALF;
            width_valid <= 1'b0;
            sync        <= 1'b0;
        end else begin
            vld_pipe    <= {vld_pipe[STAGES-1:0], tick};
            sync_pipe   <= {sync_pipe[STAGES-1:0], tick & carry};
            width_valid <= vld_pipe[STAGES];
            sync        <= sync_pipe[STAGES];
            if (tick) begin
                phase <= sum[PHASE_W-1:0];
                carry <= sum[PHASE_W];
            end
            if (vld_pipe[STAGES])
                width <= sign_s3 ? HALF - mag_s3 : HALF + mag_s3;
        end
    end

    // Datapath: qualified only by vld_pipe, so no reset needed
    always_ff @(posedge clk) begin
        if (tick) top_s0 <= phase[PHASE_W-1 -: LUT_AW+2];
        addr_s1 <= (quad == QUAD_1 || quad == QUAD_3) ? ~idx : idx;
        sign_s1 <= (quad == QUAD_2 || quad == QUAD_3);
        sign_s2 <= sign_s1;
        sign_s3 <= sign_s2;
        mag_s3  <= WIDTH_W'(prod >> AMP_W);
    end

    sine_quarter_rom #(
        .AW (LUT_AW),
        .DW (AMP_W)
    ) u_rom (
        .clk  (clk),
        .addr (addr_s1),
        .data (sample_s2)
    );
endmodule

// File: tb/tb_sine_duty_gen.sv
// Randomized and directed check of sine_duty_gen against a transaction-level model
// that computes each sample from the phase with $sin and tracks it by due cycle.
module tb_sine_duty_gen;
    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        tick = 1'b0;
    logic [31:0] ftw = '0;
    logic [31:0] width;
    logic        width_valid;
    logic        sync;

    sine_duty_gen dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .tick        (tick),
        .ftw         (ftw),
        .width       (width),
        .width_valid (width_valid),
        .sync        (sync)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int w; bit s; } pend_t;
    pend_t       pq[$];
    int          obs[$];
    bit          obs_s[$];
    logic [31:0] m_phase;
    bit          m_carry;
    int          exp_w = 500;
    bit          exp_v, exp_s;
    int          cyc = 0;
    int          n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0d want %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int w_of(input logic [31:0] ph);
        int  q, i, a, smp;
        longint mag;
        q   = int'(ph[31:30]);
        i   = int'(ph[29:22]);
        a   = (q % 2 == 1) ? 255 - i : i;
        smp = $rtoi(65535.0 * $sin(PI / 2.0 * real'(a) / 255.0) + 0.5);
        mag = (longint'(smp) * 500) >> 16;
        return (q >= 2) ? 500 - int'(mag) : 500 + int'(mag);
    endfunction

    // One clock: drive, model the edge, then check outputs at the negedge
    task automatic cycle(input bit r, input bit e, input bit t, input logic [31:0] f);
        logic [32:0] s;
        rst = r; en = e; tick = t; ftw = f;
        @(posedge clk);
        cyc++;
        exp_v = 0; exp_s = 0;
        if (r || !e) begin
            pq.delete();
            m_phase = '0; m_carry = 0; exp_w = 500;
        end else begin
            if (pq.size() > 0 && pq[0].due == cyc) begin
                exp_w = pq[0].w; exp_v = 1; exp_s = pq[0].s;
                void'(pq.pop_front());
            end
            if (t) begin
                pq.push_back('{due: cyc + 4, w: w_of(m_phase), s: m_carry});
                s = {1'b0, m_phase} + {1'b0, f};
                m_phase = s[31:0]; m_carry = s[32];
            end
        end
        @(negedge clk);
        chk("width", width, exp_w);
        chk("width_valid", width_valid, exp_v);
        chk("sync", sync, exp_s);
        if (width_valid === 1'b1) begin
            obs.push_back(int'(width));
            obs_s.push_back(sync);
        end
    endtask

    task automatic idle(input int n, input logic [31:0] f);
        for (int k = 0; k < n; k++) cycle(0, 1, 0, f);
    endtask

    task automatic flush();
        cycle(0, 0, 0, '0);
        obs.delete(); obs_s.delete();
    endtask

    initial begin
        int bad, mn, mx, nsync;
        int qt[5] = '{500, 999, 500, 1, 500};
        bit qs[5] = '{0, 0, 0, 0, 1};

        // reset held with tick active
        for (int k = 0; k < 3; k++) cycle(1, 1, 1, 32'h4000_0000);
        obs.delete(); obs_s.delete();
        cycle(0, 1, 1, 32'h4000_0000);
        idle(5, 0);
        chk("post_reset_n", obs.size(), 1);
        chk("post_reset_w", obs[0], 500);

        // quarter-turn, one tick per PWM period
        flush();
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, 1, 32'h4000_0000);
            idle(999, 32'h4000_0000);
        end
        chk("qturn_n", obs.size(), 5);
        for (int k = 0; k < 5; k++) begin
            chk("qturn_w", obs[k], qt[k]);
            chk("qturn_sync", obs_s[k], qs[k]);
        end

        // back-to-back ticks
        flush();
        for (int k = 0; k < 4; k++) cycle(0, 1, 1, 32'h4000_0000);
        idle(6, 0);
        chk("b2b_n", obs.size(), 4);
        for (int k = 0; k < 4; k++) chk("b2b_w", obs[k], qt[k]);

        // ftw=0 then en-low flush of an in-flight sample
        flush();
        cycle(0, 1, 0, 32'h1234_5678);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 1, 0);
            idle(9, 0);
        end
        chk("ftw0_n", obs.size(), 3);
        for (int k = 0; k < 3; k++) chk("ftw0_w", obs[k], 500);
        obs.delete(); obs_s.delete();
        cycle(0, 1, 1, 32'h4000_0000);
        for (int k = 0; k < 8; k++) cycle(0, 0, k % 2 == 0, 32'h4000_0000);
        chk("enlow_n", obs.size(), 0);
        cycle(0, 1, 1, 32'h4000_0000);
        idle(5, 0);
        chk("en_rise_w", obs[0], 500);

        // fine sweep across one full turn plus the first post-wrap sample
        flush();
        for (int k = 0; k < 257; k++) begin
            cycle(0, 1, 1, 32'h0100_0000);
            idle(3, 32'h0100_0000);
        end
        idle(5, 0);
        chk("sweep_n", obs.size(), 257);
        bad = 0; mn = 1 << 30; mx = -1; nsync = 0;
        for (int k = 1; k <= 256; k++) begin
            if (k <= 64 && obs[k] < obs[k-1]) bad++;
            if (k > 64 && k <= 192 && obs[k] > obs[k-1]) bad++;
            if (k > 192 && obs[k] < obs[k-1]) bad++;
        end
        for (int k = 0; k < 256; k++) begin
            if (obs[k] < mn) mn = obs[k];
            if (obs[k] > mx) mx = obs[k];
        end
        foreach (obs_s[k]) if (obs_s[k]) nsync++;
        chk("sweep_mono", bad, 0);
        chk("sweep_min", mn, 1);
        chk("sweep_max", mx, 999);
        chk("sweep_nsync", nsync, 1);
        chk("sweep_sync_at", obs_s[256], 1);
        chk("sweep_wrap_w", obs[256], 500);

        // reset two edges after a tick
        flush();
        cycle(0, 1, 1, 32'h4000_0000);
        cycle(0, 1, 0, 32'h4000_0000);
        cycle(1, 1, 0, 32'h4000_0000);
        idle(5, 32'h4000_0000);
        chk("rst_mid_n", obs.size(), 0);
        cycle(0, 1, 1, 32'h4000_0000);
        idle(5, 0);
        chk("rst_mid_w", obs[0], 500);

        // randomized traffic against the model
        for (int k = 0; k < 4000; k++)
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 31) != 0,
                  $urandom_range(0, 3) == 0, $urandom);
        idle(6, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
